// File: rtl/alu_exec.sv
// alu_exec: execute stage feeding reg_file's write port. Single-cycle ALU ops, iterative
// shifts, and a shift-add multiplier that is present only when ALU_MUL_EN is defined.
module alu_exec #(
  parameter int reg_width = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           op,
  input  logic [reg_width-1:0] rs_val,
  input  logic [reg_width-1:0] rt_val,
  input  logic [1:0]           dst_addr,
  output logic                 write,
  output logic [1:0]           rd_addr,
  output logic [reg_width-1:0] rd_in,
  output logic                 carry_flag,
  output logic                 zero_flag
);
  localparam int W  = reg_width;
  localparam int SW = $clog2(W);
  localparam int CW = $clog2(W + 1);
`ifdef ALU_MUL_EN
  localparam int AW = 2 * W;
`else
  localparam int AW = W;
`endif

  typedef enum logic [1:0] {IDLE, ITER, WB} state_t;
  typedef enum logic [2:0] {
    OP_ADD = 3'b000, OP_SUB = 3'b001, OP_AND = 3'b010, OP_OR  = 3'b011,
    OP_XOR = 3'b100, OP_SHL = 3'b101, OP_SHR = 3'b110, OP_MUL = 3'b111
  } op_t;
  typedef struct packed {
    op_t        op;
    logic [1:0] dst;
  } req_t;

  state_t         state, state_d;
  req_t           req_q;
  logic [CW-1:0]  cnt;
  logic [AW-1:0]  acc, acc_nxt;
`ifdef ALU_MUL_EN
  logic [AW-1:0]  mcand;
  logic [W-1:0]   mplier;
`endif
  logic           res_c;
  logic           xfer;
  op_t            op_in;
  logic [SW-1:0]  shamt;
  logic [W-1:0]   alu_res;
  logic           alu_c;
  logic           iter_c;
  logic           wb_write;
  logic [1:0]     wb_addr;
  logic [W-1:0]   wb_res;
  logic           wb_c;

  assign in_ready = (state == IDLE);
  assign xfer     = in_valid && in_ready;
  assign op_in    = op_t'(op);
  assign shamt    = rt_val[SW-1:0];

  // Single-cycle result; the default (rs_val, no carry) doubles as a zero-amount shift.
  always_comb begin
    alu_res = rs_val;
    alu_c   = 1'b0;
    case (op_in)
      OP_ADD: {alu_c, alu_res} = {1'b0, rs_val} + {1'b0, rt_val};
      OP_SUB: begin
        alu_res = rs_val - rt_val;
        alu_c   = (rs_val < rt_val);
      end
      OP_AND: alu_res = rs_val & rt_val;
      OP_OR:  alu_res = rs_val | rt_val;
      OP_XOR: alu_res = rs_val ^ rt_val;
      default: ;
    endcase
  end

  // One iteration step; the final step's value is written back directly.
  always_comb begin
    acc_nxt = acc;
    iter_c  = 1'b0;
    case (req_q.op)
      OP_SHL: acc_nxt[W-1:0] = {acc[W-2:0], 1'b0};
      OP_SHR: acc_nxt[W-1:0] = {1'b0, acc[W-1:1]};
`ifdef ALU_MUL_EN
      OP_MUL: begin
        acc_nxt = acc + (mplier[0] ? mcand : '0);
        iter_c  = |acc_nxt[AW-1:W];
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state;
    wb_write = 1'b0;
    wb_addr  = req_q.dst;
    wb_res   = acc_nxt[W-1:0];
    wb_c     = iter_c;
    case (state)
      IDLE: begin
        if (xfer) begin
          wb_addr = dst_addr;
          wb_res  = alu_res;
          wb_c    = alu_c;
          case (op_in)
            OP_SHL, OP_SHR: begin
              if (shamt == '0) begin
                state_d  = WB;
                wb_write = 1'b1;
              end else begin
                state_d  = ITER;
              end
            end
            OP_MUL: begin
`ifdef ALU_MUL_EN
              state_d = ITER;
`else
              // accepted but produces nothing: pass through WB without a write
              state_d = WB;
`endif
            end
            default: begin
              state_d  = WB;
              wb_write = 1'b1;
            end
          endcase
        end
      end
      ITER: begin
        if (cnt == CW'(1)) begin
          state_d  = WB;
          wb_write = 1'b1;
        end
      end
      WB:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      req_q      <= '0;
      cnt        <= '0;
      acc        <= '0;
      res_c      <= 1'b0;
      write      <= 1'b0;
      rd_addr    <= '0;
      rd_in      <= '0;
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
`ifdef ALU_MUL_EN
      mcand      <= '0;
      mplier     <= '0;
`endif
    end else begin
      state <= state_d;
      write <= wb_write;
      if (wb_write) begin
        rd_addr <= wb_addr;
        rd_in   <= wb_res;
        res_c   <= wb_c;
      end
      // flags follow the op only once its write has been presented
      if (state == WB && write) begin
        carry_flag <= res_c;
        zero_flag  <= (rd_in == '0);
      end
      if (xfer) begin
        req_q <= '{op: op_in, dst: dst_addr};
        cnt   <= (op_in == OP_MUL) ? CW'(W) : CW'(shamt);
`ifdef ALU_MUL_EN
        acc    <= (op_in == OP_MUL) ? '0 : AW'(rs_val);
        mcand  <= AW'(rs_val);
        mplier <= rt_val;
`else
        acc    <= AW'(rs_val);
`endif
      end else if (state == ITER) begin
        cnt <= cnt - CW'(1);
        acc <= acc_nxt;
`ifdef ALU_MUL_EN
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: directed cases, random ops against an arithmetic
// reference model, back-to-back transfers and reset during an iterative op.
module tb_alu_exec;
  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = '0;
  logic [W-1:0] rs_val = '0;
  logic [W-1:0] rt_val = '0;
  logic [1:0]   dst_addr = '0;
  logic         write;
  logic [1:0]   rd_addr;
  logic [W-1:0] rd_in;
  logic         carry_flag;
  logic         zero_flag;

  int n_chk = 0;
  int n_err = 0;
  int exp_rd = 0;
  int exp_addr = 0;
  bit exp_c = 1'b0;
  bit exp_z = 1'b0;

  always #5 clk = ~clk;

  alu_exec #(.reg_width(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .rs_val(rs_val), .rt_val(rt_val), .dst_addr(dst_addr),
    .write(write), .rd_addr(rd_addr), .rd_in(rd_in),
    .carry_flag(carry_flag), .zero_flag(zero_flag)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: result, carry, cycles from transfer to write, and whether a write happens.
  function automatic void model(input int o, input int a, input int b,
                                output int res, output bit c, output int lat, output bit wr);
    int k;
    int p;
    k = b % W;
    res = 0; c = 1'b0; lat = 1; wr = 1'b1;
    case (o)
      0: begin p = a + b; res = p & MASK; c = (p > MASK); end
      1: begin res = (a - b) & MASK; c = (a < b); end
      2: res = a & b;
      3: res = a | b;
      4: res = a ^ b;
      5: begin res = (a << k) & MASK; lat = k + 1; end
      6: begin res = a >> k; lat = k + 1; end
      default: begin
`ifdef ALU_MUL_EN
        p = a * b; res = p & MASK; c = ((p >> W) != 0); lat = W + 1;
`else
        wr = 1'b0;
`endif
      end
    endcase
  endfunction

  task automatic run_op(input int o, input int a, input int b, input int d);
    int res, lat, wcyc, rdy_busy;
    bit c, wr;
    logic [31:0] got_rd, got_addr;
    model(o, a, b, res, c, lat, wr);
    @(negedge clk);
    check("ready_idle", in_ready, 1);
    in_valid = 1'b1; op = 3'(o); rs_val = W'(a); rt_val = W'(b); dst_addr = 2'(d);
    @(negedge clk);
    if (wr) begin
      wcyc = 0; rdy_busy = 0; got_rd = '0; got_addr = '0;
      for (int cyc = 1; cyc <= W + 4; cyc++) begin
        if (cyc > 1) @(negedge clk);
        if (in_ready) rdy_busy++;
        if (write) begin
          wcyc = cyc; got_rd = 32'(rd_in); got_addr = 32'(rd_addr);
          break;
        end
        // junk offered while busy must never be taken
        in_valid = 1'b1; op = 3'($urandom); rs_val = W'($urandom);
        rt_val = W'($urandom); dst_addr = 2'($urandom);
      end
      in_valid = 1'b0;
      check("latency", wcyc, lat);
      check("ready_busy", rdy_busy, 0);
      check("rd_addr", got_addr, d);
      check("rd_in", got_rd, res);
      @(negedge clk);
      exp_rd = res; exp_addr = d; exp_c = c; exp_z = (res == 0);
      check("write_pulse", write, 0);
      check("ready_after", in_ready, 1);
    end else begin
      in_valid = 1'b0;
      check("nomul_write", write, 0);
      check("nomul_busy", in_ready, 0);
      @(negedge clk);
      check("nomul_write2", write, 0);
      check("nomul_ready", in_ready, 1);
      check("nomul_rd_in", rd_in, exp_rd);
      check("nomul_rd_addr", rd_addr, exp_addr);
    end
    check("carry", carry_flag, exp_c);
    check("zero", zero_flag, exp_z);
  endtask

  task automatic back_to_back();
    int q[$];
    int xfers, res, lat, a, b;
    bit c, wr;
    xfers = 0;
    @(negedge clk);
    for (int cyc = 0; cyc < 12; cyc++) begin
      if (cyc > 0) @(negedge clk);
      if (write) check("b2b_rd_in", rd_in, (q.size() > 0) ? q.pop_front() : -1);
      a = $urandom_range(0, MASK); b = $urandom_range(0, MASK);
      in_valid = 1'b1; op = 3'd0; rs_val = W'(a); rt_val = W'(b); dst_addr = 2'(cyc % 4);
      if (in_ready) begin
        xfers++;
        model(0, a, b, res, c, lat, wr);
        q.push_back(res);
        exp_rd = res; exp_addr = cyc % 4; exp_c = c; exp_z = (res == 0);
      end
    end
    in_valid = 1'b0;
    check("b2b_xfers", xfers, 6);
    check("b2b_drained", q.size(), 0);
    @(negedge clk);
    check("b2b_carry", carry_flag, exp_c);
    check("b2b_zero", zero_flag, exp_z);
  endtask

  task automatic reset_mid();
    int seen;
    seen = 0;
    @(negedge clk);
    in_valid = 1'b1; dst_addr = 2'd3;
`ifdef ALU_MUL_EN
    op = 3'd7; rs_val = 8'd16; rt_val = 8'd17;
`else
    op = 3'd5; rs_val = 8'h81; rt_val = 8'd7;
`endif
    for (int cyc = 1; cyc <= W + 6; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (write) seen++;
      rst_n = (cyc == 3) ? 1'b0 : 1'b1;
    end
    check("rst_no_write", seen, 0);
    check("rst_ready", in_ready, 1);
    check("rst_rd_in", rd_in, 0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_carry", carry_flag, 0);
    check("rst_zero", zero_flag, 0);
    exp_rd = 0; exp_addr = 0; exp_c = 1'b0; exp_z = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_write", write, 0);
    check("reset_ready", in_ready, 1);
    check("reset_rd_in", rd_in, 0);
    check("reset_rd_addr", rd_addr, 0);
    check("reset_carry", carry_flag, 0);
    check("reset_zero", zero_flag, 0);
    rst_n = 1'b1;

    run_op(0, 200, 100, 1);
    run_op(1, 5, 5, 2);
    run_op(1, 3, 4, 0);
    run_op(5, 8'h81, 3, 3);
    run_op(5, 8'h81, 0, 3);
    run_op(6, 8'h81, 7, 1);
    run_op(2, 8'hF0, 8'h3C, 2);
    run_op(3, 8'hF0, 8'h0F, 0);
    run_op(4, 8'hAA, 8'hAA, 1);
    run_op(7, 16, 17, 2);
    run_op(7, 255, 255, 1);
    run_op(0, 255, 1, 3);

    for (int i = 0; i < 40; i++)
      run_op($urandom_range(0, 7), $urandom_range(0, MASK), $urandom_range(0, MASK),
             $urandom_range(0, 3));

    back_to_back();
    run_op(0, 200, 100, 1);
    reset_mid();
    run_op(0, 1, 2, 2);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
